// File: rtl/issue_queue_entry_allocator.sv
// Free-list allocator for issue-queue entries: circular index list, all-or-nothing grant, lane-ordered release.
// Define ISSUE_QUEUE_ALLOC_CHECK_EN to add an allocation bitmap that flags double frees.
module issue_queue_entry_allocator #(
    parameter int ENTRIES     = 16,
    parameter int ALLOC_WIDTH = 2,
    parameter int FREE_WIDTH  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic [ALLOC_WIDTH-1:0]                 allocReq,
    output logic                                   allocGrant,
    output logic [ALLOC_WIDTH*$clog2(ENTRIES)-1:0] allocPtr,
    input  logic [FREE_WIDTH-1:0]                  releaseValid,
    input  logic [FREE_WIDTH*$clog2(ENTRIES)-1:0]  releasePtr,
    output logic [$clog2(ENTRIES+1)-1:0]           freeCount,
    output logic                                   initBusy,
    output logic                                   errOverflow,
    output logic                                   errDoubleFree
);
    localparam int PTR_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_reg;
    logic [PTR_W-1:0]      list_reg [ENTRIES];
    logic [PTR_W-1:0]      head_reg;
    logic [PTR_W-1:0]      tail_reg;
    logic [PTR_W-1:0]      init_cnt_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  err_ovf_reg;

    logic                  run_active;
    logic [CNT_W-1:0]      alloc_n;
    logic [CNT_W-1:0]      alloc_take;
    logic [CNT_W-1:0]      count_after_alloc;
    logic [CNT_W-1:0]      room;
    logic [CNT_W-1:0]      rel_m;
    logic [CNT_W-1:0]      rel_take;
    logic                  overflow;
    logic [CNT_W-1:0]      alloc_rank [ALLOC_WIDTH+1];
    logic [CNT_W-1:0]      rel_rank   [FREE_WIDTH+1];
    logic [PTR_W-1:0]      alloc_idx  [ALLOC_WIDTH];
    logic [PTR_W-1:0]      rel_idx    [FREE_WIDTH];
    logic [PTR_W-1:0]      rel_ptr    [FREE_WIDTH];
    logic [FREE_WIDTH-1:0] rel_apply;

    // Prefix popcounts give each active lane its compacted slot relative to head/tail.
    always_comb begin
        alloc_rank[0] = '0;
        for (int w = 0; w < ALLOC_WIDTH; w++) begin
            alloc_rank[w+1] = alloc_rank[w] + CNT_W'(allocReq[w]);
        end
    end

    always_comb begin
        rel_rank[0] = '0;
        for (int f = 0; f < FREE_WIDTH; f++) begin
            rel_rank[f+1] = rel_rank[f] + CNT_W'(releaseValid[f]);
        end
    end

    assign run_active        = (state_reg == ST_RUN) && !flush;
    assign alloc_n           = alloc_rank[ALLOC_WIDTH];
    assign rel_m             = rel_rank[FREE_WIDTH];
    assign allocGrant        = run_active && (alloc_n <= count_reg);
    assign alloc_take        = allocGrant ? alloc_n : '0;
    assign count_after_alloc = count_reg - alloc_take;
    // Space left for releases once this cycle's grant is taken out.
    assign room              = CNT_W'(ENTRIES) - count_after_alloc;
    assign overflow          = run_active && (rel_m > room);
    assign rel_take          = overflow ? room : (run_active ? rel_m : '0);

    genvar gi;
    generate
        for (gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_alloc_lane
            assign alloc_idx[gi]                 = head_reg + alloc_rank[gi][PTR_W-1:0];
            assign allocPtr[gi*PTR_W +: PTR_W]   = list_reg[alloc_idx[gi]];
        end
        for (gi = 0; gi < FREE_WIDTH; gi++) begin : g_release_lane
            assign rel_ptr[gi]   = releasePtr[gi*PTR_W +: PTR_W];
            assign rel_idx[gi]   = tail_reg + rel_rank[gi][PTR_W-1:0];
            assign rel_apply[gi] = run_active && releaseValid[gi] && (rel_rank[gi] < room);
        end
    endgenerate

    // List storage needs no reset: INIT rewrites every slot before it is read.
    always_ff @(posedge clk) begin
        if ((state_reg == ST_INIT) && !flush) begin
            list_reg[init_cnt_reg] <= init_cnt_reg;
        end
        for (int f = 0; f < FREE_WIDTH; f++) begin
            if (rel_apply[f]) begin
                list_reg[rel_idx[f]] <= rel_ptr[f];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            init_cnt_reg <= '0;
            err_ovf_reg  <= 1'b0;
        end else if (flush) begin
            state_reg    <= ST_INIT;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            init_cnt_reg <= '0;
        end else if (state_reg == ST_INIT) begin
            init_cnt_reg <= init_cnt_reg + PTR_W'(1);
            if (init_cnt_reg == PTR_W'(ENTRIES - 1)) begin
                state_reg <= ST_RUN;
                count_reg <= CNT_W'(ENTRIES);
                head_reg  <= '0;
                tail_reg  <= '0;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end else begin
            head_reg  <= head_reg + alloc_take[PTR_W-1:0];
            tail_reg  <= tail_reg + rel_take[PTR_W-1:0];
            count_reg <= count_after_alloc + rel_take;
            if (overflow) begin
                err_ovf_reg <= 1'b1;
            end
        end
    end

    assign freeCount   = count_reg;
    assign initBusy    = (state_reg == ST_INIT);
    assign errOverflow = err_ovf_reg;

`ifdef ISSUE_QUEUE_ALLOC_CHECK_EN
    logic [ENTRIES-1:0] bitmap_reg;
    logic [ENTRIES-1:0] bitmap_next;
    logic               dfree_hit;
    logic               err_dfree_reg;

    // Flagged lanes are still pushed; the check only observes, it never alters list behaviour.
    always_comb begin
        bitmap_next = bitmap_reg;
        dfree_hit   = 1'b0;
        for (int f = 0; f < FREE_WIDTH; f++) begin
            if (releaseValid[f]) begin
                if (!bitmap_reg[rel_ptr[f]]) begin
                    dfree_hit = 1'b1;
                end
                for (int g = 0; g < f; g++) begin
                    if (releaseValid[g] && (rel_ptr[g] == rel_ptr[f])) begin
                        dfree_hit = 1'b1;
                    end
                end
            end
            if (rel_apply[f]) begin
                bitmap_next[rel_ptr[f]] = 1'b0;
            end
        end
        if (allocGrant) begin
            for (int w = 0; w < ALLOC_WIDTH; w++) begin
                if (allocReq[w]) begin
                    bitmap_next[allocPtr[w*PTR_W +: PTR_W]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitmap_reg    <= '0;
            err_dfree_reg <= 1'b0;
        end else if (state_reg == ST_INIT) begin
            bitmap_reg <= '0;
        end else if (!flush) begin
            bitmap_reg <= bitmap_next;
            if (dfree_hit) begin
                err_dfree_reg <= 1'b1;
            end
        end
    end

    assign errDoubleFree = err_dfree_reg;
`else
    assign errDoubleFree = 1'b0;
`endif

endmodule

// File: tb/tb_issue_queue_entry_allocator.sv
// Scoreboard bench for issue_queue_entry_allocator: a FIFO free-list model predicts each cycle's outputs.
module tb_issue_queue_entry_allocator;
    localparam int ENTRIES = 16;
    localparam int AW      = 2;
    localparam int FW      = 2;
    localparam int PTR_W   = 4;
    localparam int CNT_W   = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic [AW-1:0]      allocReq = '0;
    logic               allocGrant;
    logic [AW*PTR_W-1:0] allocPtr;
    logic [FW-1:0]      releaseValid = '0;
    logic [FW*PTR_W-1:0] releasePtr = '0;
    logic [CNT_W-1:0]   freeCount;
    logic               initBusy;
    logic               errOverflow;
    logic               errDoubleFree;

    always #5 clk = ~clk;

    issue_queue_entry_allocator #(
        .ENTRIES    (ENTRIES),
        .ALLOC_WIDTH(AW),
        .FREE_WIDTH (FW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .allocReq     (allocReq),
        .allocGrant   (allocGrant),
        .allocPtr     (allocPtr),
        .releaseValid (releaseValid),
        .releasePtr   (releasePtr),
        .freeCount    (freeCount),
        .initBusy     (initBusy),
        .errOverflow  (errOverflow),
        .errDoubleFree(errDoubleFree)
    );

    typedef struct {
        logic       grant;
        logic [1:0] pmask;
        int         p0;
        int         p1;
        int         fc;
        logic       busy;
        logic       ovf;
        logic       dfree;
    } exp_t;

    exp_t exp_q[$];
    int   m_free[$];
    int   outst[$];
    int   m_init_left = ENTRIES;
    bit   m_ovf = 1'b0;
    bit   m_dfree = 1'b0;
    bit   m_alloc[ENTRIES];
    int   n_compared = 0;
    int   n_mismatch = 0;
    int   txn = 0;

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_compared++;
        if (obs != expv) begin
            n_mismatch++;
            $display("FAIL %s: got %0d, expected %0d (txn %0d)", tag, obs, expv, txn);
        end
    endtask

    task automatic model_step(input bit rst_v, input bit fl, input logic [1:0] req,
                              input logic [1:0] rv, input int rp0, input int rp1, input bit grant);
        int p;
        int room;
        if (!rst_v) begin
            m_init_left = ENTRIES;
            m_free.delete();
            outst.delete();
            m_ovf = 1'b0;
            m_dfree = 1'b0;
            for (int i = 0; i < ENTRIES; i++) m_alloc[i] = 1'b0;
            return;
        end
        if (fl) begin
            m_init_left = ENTRIES;
            m_free.delete();
            outst.delete();
            return;
        end
        if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    m_free.push_back(i);
                    m_alloc[i] = 1'b0;
                end
            end
            return;
        end
        if (rv[0] && !m_alloc[rp0]) m_dfree = 1'b1;
        if (rv[1] && (!m_alloc[rp1] || (rv[0] && rp0 == rp1))) m_dfree = 1'b1;
        if (grant) begin
            for (int w = 0; w < AW; w++) begin
                if (req[w]) begin
                    p = m_free.pop_front();
                    m_alloc[p] = 1'b1;
                    outst.push_back(p);
                end
            end
        end
        room = ENTRIES - m_free.size();
        for (int f = 0; f < FW; f++) begin
            if (rv[f]) begin
                p = (f == 0) ? rp0 : rp1;
                if (room > 0) begin
                    m_free.push_back(p);
                    m_alloc[p] = 1'b0;
                    room--;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic do_cycle(input bit rst_v, input bit fl, input logic [1:0] req,
                            input logic [1:0] rv, input int rp0, input int rp1);
        exp_t e;
        exp_t got;
        int   n;
        e = '{grant: 1'b0, pmask: 2'b00, p0: 0, p1: 0, fc: 0, busy: 1'b0, ovf: 1'b0, dfree: 1'b0};
        @(negedge clk);
        rst_n        = rst_v;
        flush        = fl;
        allocReq     = req;
        releaseValid = rv;
        releasePtr   = {PTR_W'(rp1), PTR_W'(rp0)};
        if (rst_v) begin
            n      = int'(req[0]) + int'(req[1]);
            e.busy = (m_init_left > 0);
            e.fc   = e.busy ? (ENTRIES - m_init_left) : m_free.size();
            e.grant = !e.busy && !fl && (n <= m_free.size());
            if (e.grant) begin
                e.pmask = req;
                if (req[0]) e.p0 = m_free[0];
                if (req[1]) e.p1 = req[0] ? m_free[1] : m_free[0];
            end
            e.ovf = m_ovf;
`ifdef ISSUE_QUEUE_ALLOC_CHECK_EN
            e.dfree = m_dfree;
`else
            e.dfree = 1'b0;
`endif
            exp_q.push_back(e);
        end
        #2;
        if (rst_v) begin
            got = exp_q.pop_front();
            txn++;
            $display("txn %0d: flush=%b req=%b rel=%b grant=%b ptr=%h free=%0d busy=%b ovf=%b dfree=%b",
                     txn, fl, req, rv, allocGrant, allocPtr, freeCount, initBusy, errOverflow, errDoubleFree);
            check_eq("allocGrant", int'(allocGrant), int'(got.grant));
            check_eq("freeCount", int'(freeCount), got.fc);
            check_eq("initBusy", int'(initBusy), int'(got.busy));
            check_eq("errOverflow", int'(errOverflow), int'(got.ovf));
            check_eq("errDoubleFree", int'(errDoubleFree), int'(got.dfree));
            if (got.pmask[0]) check_eq("allocPtr0", int'(allocPtr[3:0]), got.p0);
            if (got.pmask[1]) check_eq("allocPtr1", int'(allocPtr[7:4]), got.p1);
        end
        model_step(rst_v, fl, req, rv, rp0, rp1, e.grant);
    endtask

    initial begin
        int a;
        int b;
        int idx;
        logic [1:0] req;
        logic [1:0] rv;

        do_cycle(0, 0, 2'b00, 2'b00, 0, 0);
        do_cycle(0, 0, 2'b00, 2'b00, 0, 0);

        // Re-init: requests must be refused and releases ignored for 16 cycles.
        for (int i = 0; i < ENTRIES; i++) do_cycle(1, 0, 2'b11, 2'b01, 7, 0);

        do_cycle(1, 0, 2'b11, 2'b00, 0, 0);
        do_cycle(1, 0, 2'b10, 2'b00, 0, 0);

        // Drain to one free entry, then an oversized request alongside a release.
        for (int i = 0; i < 6; i++) do_cycle(1, 0, 2'b11, 2'b00, 0, 0);
        idx = -1;
        foreach (outst[k]) if (outst[k] == 5) idx = k;
        if (idx >= 0) outst.delete(idx);
        do_cycle(1, 0, 2'b11, 2'b01, 5, 0);
        do_cycle(1, 0, 2'b11, 2'b00, 0, 0);

        // Steady one-in/one-out traffic wraps head and tail.
        a = outst.pop_front();
        b = outst.pop_front();
        do_cycle(1, 0, 2'b00, 2'b11, a, b);
        for (int i = 0; i < 40; i++) begin
            a = outst.pop_front();
            do_cycle(1, 0, 2'b01, 2'b01, a, 0);
        end

        for (int i = 0; i < 60; i++) begin
            req = 2'($urandom_range(0, 3));
            rv  = 2'b00;
            a   = 0;
            b   = 0;
            if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
                rv[0] = 1'b1;
                a = outst.pop_front();
            end
            if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
                rv[1] = 1'b1;
                b = outst.pop_front();
            end
            do_cycle(1, 0, req, rv, a, b);
        end

        // Flush beats same-cycle alloc and release, then a full re-init.
        do_cycle(1, 1, 2'b11, 2'b01, 9, 0);
        for (int i = 0; i < ENTRIES; i++) do_cycle(1, 0, 2'b00, 2'b00, 0, 0);

        // Release into a full list: overflow, dropped lane, list still 0..15.
        do_cycle(1, 0, 2'b00, 2'b01, 3, 0);
        for (int i = 0; i < ENTRIES / 2; i++) do_cycle(1, 0, 2'b11, 2'b00, 0, 0);
        do_cycle(1, 0, 2'b01, 2'b00, 0, 0);

        // Reset clears the sticky errors.
        do_cycle(0, 0, 2'b00, 2'b00, 0, 0);
        do_cycle(0, 0, 2'b00, 2'b00, 0, 0);
        do_cycle(1, 0, 2'b00, 2'b00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
